jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter built as a bank of WIDTH JK flip-flop stages.
- For every stage, the block computes the J/K excitation needed to reach the next count, and applies JK update semantics on the clock edge.
- Sits directly upstream of the per-bit JK stages. It exposes j_vec/k_vec so the same excitation can drive external jk stages or be checked by the bench.
- Provides terminal-count and load-error flags for cascading and for control logic.

Parameters:
- WIDTH, 4, number of JK stages / count bits.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2^WIDTH; an illegal MODULUS is a static elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; clock clk.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous load request.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count (state of the JK stages).
- j_vec  output  WIDTH  J excitation per stage for the coming edge (combinational).
- k_vec  output  WIDTH  K excitation per stage for the coming edge (combinational).
- tc  output  1  terminal count (combinational).
- load_err  output  1  registered one-cycle pulse on an out-of-range load.

Behaviour:
- Reset (async, immediate, no clock needed): q=0, load_err=0. With inputs idle, j_vec=k_vec=0 and tc=0 while reset is held.
- Target next state, evaluated in priority order:
  - load=1 and load_val < MODULUS: target = load_val.
  - load=1 and load_val >= MODULUS: target = 0.
  - load=0, en=1, up_dn=1: target = (q==MODULUS-1) ? 0 : q+1.
  - load=0, en=1, up_dn=0: target = (q==0) ? MODULUS-1 : q-1.
  - otherwise: target = q.
- Excitation per bit i, computed from q[i] and target[i]:
  - q=0, target=1: J=1, K=0 (set).
  - q=1, target=0: J=0, K=1 (reset).
  - q equal to target: J=0, K=0 (hold).
  - J=K=1 (toggle) is never generated.
- Stage update on rising clk:
  - J/K = 00: hold.
  - 01: clear.
  - 10: set.
  - 11: toggle. Implemented for completeness even though it is unreachable.
  - Net effect: q <= target, with one-cycle latency from inputs to q.
- tc = en & ~load & ((up_dn & q==MODULUS-1) | (~up_dn & q==0)).
  - tc is high in the cycle before a wrap, so it is suitable as the en of a cascaded counter.
- load_err:
  - Set to 1 on the edge where load=1 and load_val >= MODULUS.
  - Returns to 0 on the next edge unless the condition repeats.
- Boundary conditions:
  - Simultaneous load and en: load wins and en is ignored; tc=0.
  - up_dn changing on any cycle: direction takes effect at the next edge; there is no glitch state.
  - Reset asserted mid-count: q goes to 0 asynchronously and load_err clears. On the first edge after deassertion, normal counting resumes from 0.
  - MODULUS == 2^WIDTH: wrap coincides with natural overflow and behaves identically to the general case.
  - q never holds a value >= MODULUS.

Test Plan:
- Reset with en=1, up_dn=1: q=0 immediately, without waiting for a clock edge. Release reset, run 12 clocks: q = 1,2,...,9,0,1,2. tc=1 only while q=9.
- q=0, en=1, up_dn=0: next q=9 with tc=1 beforehand. During the edge q 9->8: bit0 has j=0,k=1; bit3 holds (j=0,k=0).
- q=5, load=1, load_val=7, en=1, up_dn=1: next q=7, not 6; tc=0 in the load cycle; load_err stays 0.
- load=1, load_val=12 (MODULUS=10): next q=0 and load_err=1 for exactly one cycle. A back-to-back illegal load keeps load_err=1 for 2 cycles.
- Count up to q=6, then assert reset between edges: q=0 with no clock edge. Deassert: q=1 after the next edge.
- en=0, load=0 for 5 clocks at q=3: q stays 3, j_vec=k_vec=0, tc=0 throughout.

Source files
------------

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK stages.
// The per-stage J/K excitation is exported so external stages can follow the same count.
module jk_mod_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] j_vec,
   output logic [WIDTH-1:0] k_vec,
   output logic             tc,
   output logic             load_err
);

   generate
      if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
         $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
      end
   endgenerate

   // One extra bit so MODULUS == 2**WIDTH still compares correctly.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

   logic             load_bad;
   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] q_next;

   assign load_bad = load & ({1'b0, load_val} >= MOD_EXT);

   always_comb begin
      target = q;
      if (load) begin
         target = load_bad ? '0 : load_val;
      end else if (en) begin
         if (up_dn) target = (q == Q_MAX)       ? '0    : q + WIDTH'(1);
         else       target = (q == '0)          ? Q_MAX : q - WIDTH'(1);
      end
   end

   // Set only where a 0 must become 1, clear only where a 1 must become 0.
   assign j_vec = ~q & target;
   assign k_vec = q & ~target;

   always_comb begin
      q_next = q;
      for (int i = 0; i < WIDTH; i++) begin
         case ({j_vec[i], k_vec[i]})
            2'b00:   q_next[i] = q[i];
            2'b01:   q_next[i] = 1'b0;
            2'b10:   q_next[i] = 1'b1;
            default: q_next[i] = ~q[i];
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q        <= '0;
         load_err <= 1'b0;
      end else begin
         q        <= q_next;
         load_err <= load_bad;
      end
   end

   assign tc = en & ~load & ((up_dn & (q == Q_MAX)) | (~up_dn & (q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: stimulus pushes expected state, a monitor pops and compares.
module tb_jk_mod_counter;
   localparam int W = 4;
   localparam int M = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         en, up_dn, load;
   logic [W-1:0] load_val;
   logic [W-1:0] q, j_vec, k_vec;
   logic         tc, load_err;

   jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .q(q), .j_vec(j_vec), .k_vec(k_vec),
      .tc(tc), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] q;
      logic         err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_q      = 0;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: the counter presents a new state after every rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q", int'(q), int'(e.q));
            check("load_err", int'(load_err), int'(e.err));
         end
      end
   end

   task automatic step(input logic i_en, input logic i_up, input logic i_load, input int i_val);
      int   tgt;
      logic bad;
      logic [W-1:0] ej, ek;
      int   etc;
      exp_t e;
      @(negedge clk);
      en = i_en; up_dn = i_up; load = i_load; load_val = W'(i_val);
      bad = i_load && (i_val >= M);
      if (i_load)    tgt = bad ? 0 : i_val;
      else if (i_en) tgt = i_up ? (m_q + 1) % M : (m_q + M - 1) % M;
      else           tgt = m_q;
      for (int i = 0; i < W; i++) begin
         ej[i] = !((m_q >> i) & 1) && ((tgt >> i) & 1);
         ek[i] = ((m_q >> i) & 1) && !((tgt >> i) & 1);
      end
      etc = (i_en && !i_load && ((i_up && m_q == M-1) || (!i_up && m_q == 0))) ? 1 : 0;
      #1;
      check("tc", int'(tc), etc);
      check("j_vec", int'(j_vec), int'(ej));
      check("k_vec", int'(k_vec), int'(ek));
      e.q = W'(tgt);
      e.err = bad;
      exp_q.push_back(e);
      m_q = tgt;
      @(posedge clk);
      #2;
   endtask

   // Assert reset between edges and confirm it acts without a clock.
   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      check("async_reset_q", int'(q), 0);
      check("async_reset_err", int'(load_err), 0);
      m_q = 0;
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;
      #2;
      check("reset_q", int'(q), 0);
      check("reset_err", int'(load_err), 0);
      en = 1'b0;
      #1;
      check("reset_idle_j", int'(j_vec), 0);
      check("reset_idle_k", int'(k_vec), 0);
      check("reset_idle_tc", int'(tc), 0);
      @(negedge clk);
      #2 reset = 1'b0;
      m_q = 0;

      for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
      step(0, 1, 1, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 1, 5);
      step(1, 1, 1, 7);
      step(0, 1, 1, 12);
      step(0, 1, 0, 0);
      step(0, 1, 1, 12);
      step(0, 1, 1, 15);
      step(0, 1, 0, 0);
      step(0, 1, 1, 5);
      step(1, 1, 0, 0);
      pulse_reset();
      step(1, 1, 0, 0);
      step(0, 1, 1, 3);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(39) == 0) pulse_reset();
         step($urandom_range(3) != 0, 1'($urandom), $urandom_range(4) == 0,
              int'($urandom_range(15)));
      end

      repeat (2) @(posedge clk);
      #3;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
